// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with a shared wait-stated memory, and traps illegal opcodes and memory timeouts.
//
// state  | meaning
// FETCH  | request instruction at PC; on accept load IR and PC+4
// DECODE | classify opcode into op_class
// EXEC   | ALU operation for the class (branch resolves here)
// MEM    | data load/store at ALU address
// WB     | register write-back, jump PC update
// HALT   | illegal opcode or bus timeout; leaves only through reset
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter bit          SUPPORT_JALR = 1'b1,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic [1:0] memtoreg,
  output logic [1:0] ALUop,
  output logic       ALUsrc,
  output logic       regwrite,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI
  } op_class_e;

  state_e             state_q, state_d;
  op_class_e          op_class_q, op_class_d;
  op_class_e          dec_class;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               waiting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      op_class_q <= C_NOP;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_class_q <= op_class_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    dec_class = C_NOP;
    case (opcode)
      7'b0110011: dec_class = C_R;
      7'b0010011: dec_class = C_I;
      7'b0000011: dec_class = C_LOAD;
      7'b0100011: dec_class = C_STORE;
      7'b1100011: dec_class = C_BRANCH;
      7'b1100111: dec_class = SUPPORT_JALR ? C_JALR : C_NOP;
      7'b0110111: dec_class = C_LUI;
      7'b1101111: dec_class = C_JAL;
      default:    dec_class = C_NOP;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_class_d = op_class_q;
    wait_cnt_d = wait_cnt_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    memtoreg   = 2'b00;
    ALUop      = 2'b00;
    ALUsrc     = 1'b0;
    regwrite   = 1'b0;
    retire     = 1'b0;
    illegal    = illegal_q;
    bus_err    = bus_err_q;

    case (state_q)
      S_FETCH: begin
        mem_req = run_en;
        if (run_en && mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        op_class_d = dec_class;
        case (dec_class)
          C_LUI, C_JAL: state_d = S_WB;
          C_NOP: begin
            if (ILLEGAL_HALT) begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end else begin
              illegal = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_class_q)
          C_R:             begin ALUop = 2'b11; state_d = S_WB; end
          C_I:             begin ALUop = 2'b10; ALUsrc = 1'b1; state_d = S_WB; end
          C_LOAD, C_STORE: begin ALUsrc = 1'b1; state_d = S_MEM; end
          C_JALR:          begin ALUsrc = 1'b1; state_d = S_WB; end
          C_BRANCH: begin
            ALUop   = 2'b01;
            branch  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op_class_q == C_STORE);
        if (mem_ready) begin
          if (op_class_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
        case (op_class_q)
          C_LOAD: memtoreg = 2'b01;
          C_LUI:  memtoreg = 2'b11;
          C_JAL:  begin memtoreg = 2'b10; jal  = 1'b1; pc_write = 1'b1; end
          C_JALR: begin memtoreg = 2'b10; jalr = 1'b1; pc_write = 1'b1; end
          default: memtoreg = 2'b00;
        endcase
      end
      default: state_d = S_HALT;
    endcase

    // Timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT;
    // an accepted request never counts as waiting, so acceptance wins.
    waiting = mem_req && !mem_ready;
    if ((MEM_TIMEOUT != 0) && waiting && ((32'(wait_cnt_q) + 32'd1) == MEM_TIMEOUT)) begin
      state_d   = S_HALT;
      bus_err_d = 1'b1;
    end

    if (!mem_req || mem_ready || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    if (!rst_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      iord     = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      branch   = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      memtoreg = 2'b00;
      ALUop    = 2'b00;
      ALUsrc   = 1'b0;
      regwrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
      bus_err  = 1'b0;
    end
  end

  assign state = state_q;

endmodule
